// File: rtl/child_slot_dispatcher.sv
// child_slot_dispatcher
//   One-entry buffered feeder that deals transactions out to NUM_CHILD child
//   slots in strict round-robin order. A stalled slot blocks the stream, so
//   no slot is ever skipped. Completed dispatches are counted (saturating).
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : upstream transaction valid
//   in_ready   : dispatcher can accept this cycle
//   in_data    : upstream payload
//   out_valid  : one-hot valid toward the target slot (zero when empty)
//   out_ready  : per-slot ready; only the selected slot's bit is used
//   out_data   : held payload, shared by all slots
//   out_sel    : index of the current target slot (valid even when empty)
//   busy       : holding register occupied
//   disp_count : number of completed dispatches, saturating
//
// State | meaning
// EMPTY | holding register free; out_valid is zero
// FULL  | holding register occupied; out_valid = one-hot(ptr)

module child_slot_dispatcher #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = $clog2(NUM_CHILD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_CHILD-1:0] out_valid,
  input  logic [NUM_CHILD-1:0] out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 busy,
  output logic [CNT_W-1:0]     disp_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_fire;
  logic               out_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        data_q <= in_data;
      end
      if (out_fire) begin
        ptr_q <= (ptr_q == SEL_W'(NUM_CHILD - 1)) ? '0 : ptr_q + 1'b1;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // in_ready looks through out_ready[ptr] so a draining entry can be
  // replaced in the same cycle, giving one transaction per cycle.
  always_comb begin
    state_d   = state_q;
    out_valid = '0;
    out_fire  = 1'b0;
    in_ready  = 1'b0;
    in_fire   = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_fire) begin
          state_d = FULL;
        end
      end
      FULL: begin
        out_valid[ptr_q] = 1'b1;
        out_fire         = out_ready[ptr_q];
        in_ready         = out_fire;
        in_fire          = in_valid & out_fire;
        if (out_fire && !in_fire) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign out_data   = data_q;
  assign out_sel    = ptr_q;
  assign busy       = (state_q == FULL);
  assign disp_count = cnt_q;

endmodule

// File: tb/tb_child_slot_dispatcher.sv
module tb_child_slot_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [4:0]  out_ready;

  logic        in_ready;
  logic [4:0]  out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_sel;
  logic        busy;
  logic [15:0] disp_count;

  logic        s_in_ready;
  logic [4:0]  s_out_valid;
  logic [15:0] s_out_data;
  logic [2:0]  s_out_sel;
  logic        s_busy;
  logic [3:0]  s_disp_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  child_slot_dispatcher #(.NUM_CHILD(5), .DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .busy(busy),
    .disp_count(disp_count)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  child_slot_dispatcher #(.NUM_CHILD(5), .DATA_W(16), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_sel(s_out_sel), .busy(s_busy),
    .disp_count(s_disp_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] stream_valid [6];

  initial begin
    stream_valid = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = '0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // reset then idle
    chk("rst_out_valid", out_valid, 5'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_sel", out_sel, 3'd0);
    chk("rst_disp_count", disp_count, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 16'h0);

    // streaming 0x0A..0x0F
    out_ready = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h000A + 16'(i);
      tick();
      chk("stream_valid", out_valid, stream_valid[i]);
      chk("stream_data", out_data, 16'h000A + 16'(i));
      chk("stream_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_busy", busy, 1'b0);
    chk("stream_count", disp_count, 16'd6);
    chk("stream_sel", out_sel, 3'd1);

    // simultaneous in/out fire, then hold at ptr 3 and reset
    in_valid = 1'b1; in_data = 16'h0021;
    tick();
    chk("sim_busy0", busy, 1'b1);
    in_data = 16'h0022;
    #1;
    chk("sim_in_ready", in_ready, 1'b1);
    tick();
    chk("sim_busy1", busy, 1'b1);
    chk("sim_valid", out_valid, 5'b00100);
    chk("sim_data", out_data, 16'h0022);
    chk("sim_count", disp_count, 16'd7);
    in_data = 16'h0033;
    tick();
    chk("sim_count2", disp_count, 16'd8);
    in_valid = 1'b0; out_ready = 5'b00000;
    #1;
    chk("hold3_in_ready", in_ready, 1'b0);
    tick();
    chk("hold3_valid", out_valid, 5'b01000);
    chk("hold3_data", out_data, 16'h0033);
    chk("hold3_sel", out_sel, 3'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_valid", out_valid, 5'b0);
    chk("mrst_sel", out_sel, 3'd0);
    chk("mrst_data", out_data, 16'h0);
    out_ready = 5'b11111;
    tick();
    chk("mrst_no_replay_valid", out_valid, 5'b0);
    chk("mrst_no_replay_count", disp_count, 16'd0);

    // backpressure on slot 0
    out_ready = 5'b11110;
    in_valid = 1'b1; in_data = 16'h0055;
    tick();
    in_data = 16'h0066;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 5'b00001);
      chk("bp_data", out_data, 16'h0055);
      tick();
    end
    chk("bp_count_held", disp_count, 16'd0);
    in_valid = 1'b0; out_ready = 5'b11111;
    tick();
    chk("bp_rel_busy", busy, 1'b0);
    chk("bp_rel_sel", out_sel, 3'd1);
    chk("bp_rel_count", disp_count, 16'd1);
    chk("bp_rel_data", out_data, 16'h0055);

    // 20 dispatches: saturation on the narrow counter, ptr wrap on both
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0100 + 16'(i);
      tick();
      chk("sat_valid", out_valid, 5'b1 << ((1 + i) % 5));
      chk("sat_data", out_data, 16'h0100 + 16'(i));
      chk("sat_s_valid", s_out_valid, 5'b1 << ((1 + i) % 5));
    end
    in_valid = 1'b0;
    tick();
    chk("sat_count_wide", disp_count, 16'd21);
    chk("sat_count_narrow", s_disp_count, 4'hF);
    chk("sat_sel", out_sel, 3'd1);
    chk("sat_s_sel", s_out_sel, 3'd1);
    chk("sat_s_busy", s_busy, 1'b0);
    chk("sat_s_in_ready", s_in_ready, 1'b1);
    chk("sat_s_data", s_out_data, 16'h0113);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
